// File: rtl/reset_sequencer.sv
// Staged reset generator: synchronizes external reset release, holds, then releases
// rst_out bits one at a time (bit 0 first) and keeps a free-running cycle count.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 5,
    parameter int NUM_STAGES  = 3,
    parameter int STAGE_GAP   = 4,
    parameter int COUNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_rst_req,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [COUNT_W-1:0]    cycle_count
);

    localparam int MAX_WAIT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {SYNC, HOLD, RELEASE, RUN} state_t;

    state_t                state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                  rst_sync;
    logic [CNT_W-1:0]      hold_cnt;
    logic [CNT_W-1:0]      gap_cnt;
    logic [NUM_STAGES-1:0] shifted;
    logic                  hold_done;
    logic                  gap_done;

    // Synchronizer flops are set on reset so release is seen only after a 0 walks through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync  = sync_ff[SYNC_STAGES-1];
    assign shifted   = rst_out << 1;
    assign hold_done = (hold_cnt == CNT_W'(HOLD_CYCLES - 1));
    assign gap_done  = (gap_cnt == CNT_W'(STAGE_GAP - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (!rst_sync) begin
            cycle_count <= cycle_count + COUNT_W'(1);
        end
    end

    // Bits release in index order, so a left shift of rst_out clears exactly the next stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SYNC;
            rst_out  <= '1;
            ready    <= 1'b0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
        end else if (state != SYNC && soft_rst_req) begin
            state    <= HOLD;
            rst_out  <= '1;
            ready    <= 1'b0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                SYNC: begin
                    if (!rst_sync) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (hold_done) begin
                        rst_out <= shifted;
                        gap_cnt <= '0;
                        if (shifted == '0) begin
                            ready <= 1'b1;
                            state <= RUN;
                        end else begin
                            state <= RELEASE;
                        end
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (gap_done) begin
                        rst_out <= shifted;
                        gap_cnt <= '0;
                        if (shifted == '0) begin
                            ready <= 1'b1;
                            state <= RUN;
                        end
                    end else if (gap_cnt != '1) begin
                        gap_cnt <= gap_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: three instances (defaults, COUNT_W=4,
// NUM_STAGES=1/HOLD_CYCLES=1) checked every edge against an edge-number timing model.
module tb_reset_sequencer;

    typedef struct packed {
        logic [7:0]  ro;
        logic        rdy;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst_a, rst_b, rst_c;
    logic        soft_a, soft_b, soft_c;
    logic [2:0]  rst_out_a;
    logic [2:0]  rst_out_b;
    logic [0:0]  rst_out_c;
    logic        ready_a, ready_b, ready_c;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [31:0] cnt_c;

    int vectors = 0;
    int miscompares = 0;
    int e_a = 0, e_b = 0, e_c = 0;
    int base_a = 3, base_b = 3, base_c = 3;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    reset_sequencer dut_a (
        .clk(clk), .rst(rst_a), .soft_rst_req(soft_a),
        .rst_out(rst_out_a), .ready(ready_a), .cycle_count(cnt_a)
    );

    reset_sequencer #(.COUNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .soft_rst_req(soft_b),
        .rst_out(rst_out_b), .ready(ready_b), .cycle_count(cnt_b)
    );

    reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1)) dut_c (
        .clk(clk), .rst(rst_c), .soft_rst_req(soft_c),
        .rst_out(rst_out_c), .ready(ready_c), .cycle_count(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after edge e, where base is the edge HOLD was last entered.
    function automatic exp_t model(input int e, input int base, input int ss, input int hold,
                                   input int num, input int gap, input int cw);
        exp_t   r;
        longint c;
        r.ro = '0;
        for (int i = 0; i < num; i++) begin
            r.ro[i] = !(e >= ss + 1 && e >= base + hold + i * gap);
        end
        r.rdy = (e >= ss + 1) && (e >= base + hold + (num - 1) * gap);
        c = (e >= ss + 1) ? longint'(e - ss) : 0;
        r.cnt = 32'(c & ((longint'(1) << cw) - 1));
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic sa, input logic sb, input logic sc);
        exp_t ea, eb, ec;
        soft_a = sa;
        soft_b = sb;
        soft_c = sc;
        if (!rst_a) begin
            e_a++;
            if (sa && e_a > 3) base_a = e_a;
        end
        if (!rst_b) begin
            e_b++;
            if (sb && e_b > 3) base_b = e_b;
        end
        if (!rst_c) begin
            e_c++;
            if (sc && e_c > 3) base_c = e_c;
        end
        qa.push_back(model(e_a, base_a, 2, 5, 3, 4, 32));
        qb.push_back(model(e_b, base_b, 2, 5, 3, 4, 4));
        qc.push_back(model(e_c, base_c, 2, 1, 1, 4, 32));
        @(posedge clk);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        ec = qc.pop_front();
        checkOutput($sformatf("a_rst_out_e%0d", e_a), 32'(rst_out_a), 32'(ea.ro));
        checkOutput($sformatf("a_ready_e%0d", e_a), 32'(ready_a), 32'(ea.rdy));
        checkOutput($sformatf("a_count_e%0d", e_a), cnt_a, ea.cnt);
        checkOutput($sformatf("b_rst_out_e%0d", e_b), 32'(rst_out_b), 32'(eb.ro));
        checkOutput($sformatf("b_count_e%0d", e_b), 32'(cnt_b), eb.cnt);
        checkOutput($sformatf("c_rst_out_e%0d", e_c), 32'(rst_out_c), 32'(ec.ro));
        checkOutput($sformatf("c_ready_e%0d", e_c), 32'(ready_c), 32'(ec.rdy));
        checkOutput($sformatf("c_count_e%0d", e_c), cnt_c, ec.cnt);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        soft_a = 1'b0; soft_b = 1'b0; soft_c = 1'b0;

        // Tests 1, 2, 5, 6: reset for 3 cycles, then a single soft reset at edge 20.
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(k == 20, 1'b0, (k == 1) || (k == 10));
            if (k == 7)  checkOutput("t1_e7_rst_out", 32'(rst_out_a), 32'h7);
            if (k == 8)  checkOutput("t1_e8_rst_out", 32'(rst_out_a), 32'h6);
            if (k == 12) checkOutput("t1_e12_rst_out", 32'(rst_out_a), 32'h4);
            if (k == 16) checkOutput("t1_e16_ready", 32'(ready_a), 32'h1);
            if (k == 16) checkOutput("t1_e16_count", cnt_a, 32'd14);
            if (k == 20) checkOutput("t2_e20_count", cnt_a, 32'd18);
            if (k == 25) checkOutput("t2_e25_rst_out", 32'(rst_out_a), 32'h6);
            if (k == 33) checkOutput("t2_e33_rst_out", 32'(rst_out_a), 32'h0);
            if (k == 17) checkOutput("t5_e17_count", 32'(cnt_b), 32'd15);
            if (k == 18) checkOutput("t5_e18_count", 32'(cnt_b), 32'd0);
            if (k == 3)  checkOutput("t6_e3_ready", 32'(ready_c), 32'h0);
            if (k == 4)  checkOutput("t6_e4_ready", 32'(ready_c), 32'h1);
            if (k == 4)  checkOutput("t6_e4_rst_out", 32'(rst_out_c), 32'h0);
        end

        // Asynchronous reset from RUN must take effect before the next edge.
        rst_a = 1'b1;
        #1;
        checkOutput("run_async_rst_out", 32'(rst_out_a), 32'h7);
        checkOutput("run_async_count", cnt_a, 32'd0);
        e_a = 0;
        base_a = 3;
        for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b0, 1'b0);
        rst_a = 1'b0;
        for (int k = 1; k <= 10; k++) applyStimulus(1'b0, 1'b0, 1'b0);

        // Test 3: reset pulse mid-RELEASE, between edges.
        #2;
        rst_a = 1'b1;
        #1;
        checkOutput("t3_async_rst_out", 32'(rst_out_a), 32'h7);
        checkOutput("t3_async_ready", 32'(ready_a), 32'h0);
        checkOutput("t3_async_count", cnt_a, 32'd0);
        e_a = 0;
        base_a = 3;
        #1;
        rst_a = 1'b0;

        // Test 4: soft reset sampled high on edges 20..31 keeps every stage asserted.
        for (int k = 1; k <= 45; k++) begin
            applyStimulus((k >= 20) && (k <= 31), 1'b0, 1'b0);
            if (k == 8)  checkOutput("t3_e8_rst_out", 32'(rst_out_a), 32'h6);
            if (k == 16) checkOutput("t3_e16_ready", 32'(ready_a), 32'h1);
            if (k == 35) checkOutput("t4_e35_rst_out", 32'(rst_out_a), 32'h7);
            if (k == 36) checkOutput("t4_e36_rst_out", 32'(rst_out_a), 32'h6);
            if (k == 44) checkOutput("t4_e44_rst_out", 32'(rst_out_a), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
